debug_mon: RTL and testbench
============================

Name: debug_mon

Overview:
- Synthesizable memory-mapped debug monitor for the CPU data bus.
- Gives the system a parametrised, multi-channel "stdout" port and a terminate/exit-code register, so software can print and stop without testbench probing.
- Counts cycles and retired instructions, readable over the bus.
- Sits beside data RAM in `system`, decoding an 8-word window at the top of the data address space.

Parameters:
ADDR_W, 24, data address width
DATA_W, 32, bus data width
BASE_ADDR, 24'hFFFFF8, word address of register window (8 words, must be 8-aligned)
NCHAN, 2, number of output channels (1..4)
FIFO_DEPTH, 16, shared TX FIFO entries (power of 2, >=2)
CNT_W, 32, width of cycle/instruction counters (<= DATA_W)

Ports:
i_clk  in  1  clock
i_rstb  in  1  asynchronous active-low reset
i_clk_en  in  1  clock enable; all state updates qualified by it
i_addr  in  ADDR_W  CPU data address
i_wdata  in  DATA_W  CPU write data
i_wr  in  1  write strobe
i_rd  in  1  read strobe
i_retire  in  1  one instruction retired this cycle
o_rdata  out  DATA_W  registered read data
o_rd_valid  out  1  o_rdata valid
o_tx_valid  out  1  TX stream entry available
o_tx_chan  out  2  channel of head entry
o_tx_data  out  8  byte of head entry
i_tx_ready  in  1  sink accepts head entry
o_halt  out  1  terminate written
o_exit_code  out  DATA_W  value written to terminate register

Behaviour:
- Reset (async, i_rstb=0): FIFO empty, overflow flags 0, counters 0, o_halt 0, o_exit_code 0, o_rd_valid 0, o_rdata 0, o_tx_valid 0. Deassertion takes effect at the next enabled edge; reset mid-transfer discards FIFO contents.
- Hit: i_addr[ADDR_W-1:3]==BASE_ADDR[ADDR_W-1:3]; off = i_addr[2:0]. With i_clk_en=0, no state changes and outputs hold.
- Write map:
  - off 0..NCHAN-1: push {off[1:0], i_wdata[7:0]}.
  - off NCHAN..3: ignored.
  - off 6: clear overflow flag.
  - off 7: set o_halt, latch o_exit_code.
  - off 4, 5: ignored.
- Read map: off 4 = cycle count; off 5 = instr count; off 6 = {overflow[31], fill level in [15:0]}; other offsets read 0. Reads are zero-extended.
- Read latency: o_rd_valid=1 and o_rdata set exactly one enabled cycle after i_rd with hit. o_rd_valid=0 otherwise; o_rdata holds its last value.
- Counters:
  - Cycle counter +1 every enabled cycle while o_halt=0.
  - Instr counter +1 on enabled cycles with i_retire=1 while o_halt=0.
  - Both wrap modulo 2^CNT_W. Both freeze once halted.
- Halt: o_halt asserts the cycle after the terminate write and is sticky until reset. After halt, channel pushes and exit-code writes are ignored. The FIFO keeps draining; reads still work.
- FIFO (shared, in order):
  - o_tx_valid = not empty; o_tx_chan/o_tx_data = head entry, stable while valid and not ready.
  - Pop when o_tx_valid & i_tx_ready.
  - Push accepted if not full, or if full with a pop in the same cycle. Otherwise the byte is dropped and the sticky overflow flag is set.
  - Simultaneous push+pop keeps the level unchanged. Pointers wrap modulo FIFO_DEPTH. The level counter spans 0..FIFO_DEPTH.
  - First-word latency: o_tx_valid rises the cycle after the push.
- Simultaneous read and write to the same offset: the read returns the pre-write value.

Test Plan:
- Reset, then write 0x41 to BASE+0 and 0x42 to BASE+1, i_tx_ready=1 -> stream (chan0,0x41) then (chan1,0x42); o_tx_valid low afterward.
- i_tx_ready=0, push 17 bytes (0x00..0x10) at depth 16 -> level=16, read off 6 = 0x80000010, byte 0x10 dropped. Drain -> 0x00..0x0F in order. Write off 6 -> status=0x00000000.
- Full FIFO, push 0x55 with i_tx_ready=1 in the same cycle -> accepted, no overflow, 0x55 emerges last.
- Run 100 enabled cycles with 37 retire pulses, then read off 4 and off 5 -> 100+k and 37 (k = fixed cycles between reset release and read, checked by model); i_clk_en=0 gaps are not counted.
- Write 0x2A to BASE+7 -> o_halt=1 next cycle, o_exit_code=0x2A. Later push to BASE+0 ignored; counters frozen across 50 further cycles.
- CNT_W=8: 300 retires -> instr count reads 44 (wrap). Assert i_rstb low mid-drain -> all outputs 0 immediately.

Source files
------------

// File: rtl/debug_mon.sv
// Memory-mapped debug monitor: a shared multi-channel byte stream, a sticky terminate/exit-code
// register and free-running cycle / retired-instruction counters in an 8-word bus window.
module debug_mon #(
  parameter int                ADDR_W     = 24,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 24'hFFFFF8,
  parameter int                NCHAN      = 2,
  parameter int                FIFO_DEPTH = 16,
  parameter int                CNT_W      = 32
) (
  input  logic              i_clk,
  input  logic              i_rstb,
  input  logic              i_clk_en,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_wr,
  input  logic              i_rd,
  input  logic              i_retire,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rd_valid,
  output logic              o_tx_valid,
  output logic [1:0]        o_tx_chan,
  output logic [7:0]        o_tx_data,
  input  logic              i_tx_ready,
  output logic              o_halt,
  output logic [DATA_W-1:0] o_exit_code
);

  localparam int               PTR_W      = $clog2(FIFO_DEPTH);
  localparam int               LVL_W      = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL   = LVL_W'(FIFO_DEPTH);
  localparam logic [2:0]       NCHAN_OFF  = 3'(NCHAN);
  localparam logic [2:0]       OFF_CYC    = 3'd4;
  localparam logic [2:0]       OFF_INSTR  = 3'd5;
  localparam logic [2:0]       OFF_STATUS = 3'd6;
  localparam logic [2:0]       OFF_TERM   = 3'd7;

  logic [9:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              r_ovf;
  logic [CNT_W-1:0]  r_cyc_cnt, r_instr_cnt;
  logic              r_halt;
  logic [DATA_W-1:0] r_exit_code;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rd_valid;

  logic              w_hit, w_wr_en, w_not_empty, w_full;
  logic              w_push_req, w_push, w_pop;
  logic [2:0]        w_off;
  logic [9:0]        w_head;
  logic [DATA_W-1:0] w_rd_mux;

  assign w_hit       = (i_addr[ADDR_W-1:3] == BASE_ADDR[ADDR_W-1:3]);
  assign w_off       = i_addr[2:0];
  assign w_wr_en     = i_clk_en & w_hit & i_wr;
  assign w_not_empty = (r_level != '0);
  assign w_full      = (r_level == FULL_LVL);

  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign w_pop      = i_clk_en & w_not_empty & i_tx_ready;
  assign w_push_req = w_wr_en & (w_off < NCHAN_OFF) & ~r_halt;
  assign w_push     = w_push_req & (~w_full | w_pop);

  // NOTE: storage array has no reset; emptiness is defined by the level counter alone.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_off[1:0], i_wdata[7:0]};
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
    end else if (i_clk_en) begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: ;
      endcase
      if (w_push_req && !w_push)             r_ovf <= 1'b1;
      else if (w_wr_en && w_off == OFF_STATUS) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      r_cyc_cnt   <= '0;
      r_instr_cnt <= '0;
      r_halt      <= 1'b0;
      r_exit_code <= '0;
    end else if (i_clk_en && !r_halt) begin
      r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
      if (i_retire) r_instr_cnt <= r_instr_cnt + CNT_W'(1);
      if (w_wr_en && w_off == OFF_TERM) begin
        r_halt      <= 1'b1;
        r_exit_code <= i_wdata;
      end
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_rd_mux = '0;
    case (w_off)
      OFF_CYC:    w_rd_mux = DATA_W'(r_cyc_cnt);
      OFF_INSTR:  w_rd_mux = DATA_W'(r_instr_cnt);
      OFF_STATUS: begin
        w_rd_mux[DATA_W-1]  = r_ovf;
        w_rd_mux[LVL_W-1:0] = r_level;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      r_rd_valid <= 1'b0;
      r_rdata    <= '0;
    end else if (i_clk_en) begin
      r_rd_valid <= i_rd & w_hit;
      if (i_rd && w_hit) r_rdata <= w_rd_mux;
    end
  end

  // Head is masked when empty so the stream reads as zero out of reset.
  assign w_head      = r_mem[r_rd_ptr];
  assign o_tx_valid  = w_not_empty;
  assign o_tx_chan   = w_not_empty ? w_head[9:8] : 2'b00;
  assign o_tx_data   = w_not_empty ? w_head[7:0] : 8'h00;
  assign o_rdata     = r_rdata;
  assign o_rd_valid  = r_rd_valid;
  assign o_halt      = r_halt;
  assign o_exit_code = r_exit_code;

endmodule

// File: tb/tb_debug_mon.sv
// Bench for debug_mon: vector table plus multi-cycle sequences, checked against a behavioural
// scoreboard (TX byte queue, read-response queue) and hand-derived constants.
module tb_debug_mon;

  localparam int          DEPTH = 16;
  localparam int          NCHAN = 2;
  localparam logic [23:0] BASE  = 24'hFFFFF8;

  logic        clk = 1'b0;
  logic        rstb = 1'b1;
  logic        en, wr, rd, retire, tx_ready;
  logic [23:0] addr;
  logic [31:0] wdata;

  logic [31:0] rdata, exit_code, rdata8, exit_code8;
  logic        rd_valid, tx_valid, halt, rd_valid8, tx_valid8, halt8;
  logic [1:0]  tx_chan, tx_chan8;
  logic [7:0]  tx_data, tx_data8;

  debug_mon u_dut (
    .i_clk(clk), .i_rstb(rstb), .i_clk_en(en), .i_addr(addr), .i_wdata(wdata),
    .i_wr(wr), .i_rd(rd), .i_retire(retire), .o_rdata(rdata), .o_rd_valid(rd_valid),
    .o_tx_valid(tx_valid), .o_tx_chan(tx_chan), .o_tx_data(tx_data), .i_tx_ready(tx_ready),
    .o_halt(halt), .o_exit_code(exit_code)
  );

  debug_mon #(.CNT_W(8)) u_dut8 (
    .i_clk(clk), .i_rstb(rstb), .i_clk_en(en), .i_addr(addr), .i_wdata(wdata),
    .i_wr(wr), .i_rd(rd), .i_retire(retire), .o_rdata(rdata8), .o_rd_valid(rd_valid8),
    .o_tx_valid(tx_valid8), .o_tx_chan(tx_chan8), .o_tx_data(tx_data8), .i_tx_ready(tx_ready),
    .o_halt(halt8), .o_exit_code(exit_code8)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] v;
    logic [31:0] v8;
  } rd_exp_t;

  typedef struct {
    logic        wr, rd, en, rdy, miss;
    logic [2:0]  off;
    logic [7:0]  d;
    logic        exp_txv, exp_rdv;
    logic [31:0] exp_rdata;
  } vec_t;

  logic [9:0]  sb[$];
  rd_exp_t     rd_q[$];
  logic        m_ovf, m_halt, m_rdv;
  logic [31:0] m_exit, m_cyc, m_instr, m_rdata, m_rdata8;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    rd_q.delete();
    m_ovf = 0; m_halt = 0; m_rdv = 0;
    m_exit = 0; m_cyc = 0; m_instr = 0; m_rdata = 0; m_rdata8 = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " rdata"},    rdata, 0);
    check({tag, " rd_valid"}, rd_valid, 0);
    check({tag, " tx_valid"}, tx_valid, 0);
    check({tag, " tx_head"},  {tx_chan, tx_data}, 0);
    check({tag, " halt"},     halt, 0);
    check({tag, " exit"},     exit_code, 0);
    check({tag, " rdata8"},   rdata8, 0);
    check({tag, " txv8"},     tx_valid8, 0);
  endtask

  task automatic set_in(input logic w, input logic r, input logic [2:0] off,
                        input logic [31:0] d, input logic rdy, input logic e,
                        input logic ret, input logic miss);
    wr = w; rd = r; wdata = d; tx_ready = rdy; en = e; retire = ret;
    addr = miss ? {BASE[23:3] - 21'd1, off} : {BASE[23:3], off};
  endtask

  // One clock: advance the model with the current inputs, take the edge, compare at edge+1.
  task automatic cycle();
    logic       hit, pop, push_req;
    logic [2:0] off;
    logic [31:0] rv, rv8;
    int         sz;
    rd_exp_t    e;
    hit = (addr[23:3] == BASE[23:3]);
    off = addr[2:0];
    if (en) begin
      sz  = sb.size();
      pop = tx_ready && (sz > 0);
      if (rd && hit) begin
        rv = 0;
        case (off)
          3'd4: rv = m_cyc;
          3'd5: rv = m_instr;
          3'd6: rv = {m_ovf, 15'b0, 16'(sz)};
          default: rv = 0;
        endcase
        rv8 = (off == 3'd4 || off == 3'd5) ? (rv & 32'hFF) : rv;
        e.v = rv; e.v8 = rv8;
        rd_q.push_back(e);
      end
      m_rdv = rd && hit;
      if (pop) void'(sb.pop_front());
      push_req = wr && hit && (int'(off) < NCHAN) && !m_halt;
      if (push_req) begin
        if (sz < DEPTH || pop) sb.push_back({off[1:0], wdata[7:0]});
        else m_ovf = 1;
      end
      if (wr && hit && off == 3'd6) m_ovf = 0;
      if (!m_halt) begin
        m_cyc++;
        if (retire) m_instr++;
        if (wr && hit && off == 3'd7) begin
          m_halt = 1;
          m_exit = wdata;
        end
      end
    end
    @(posedge clk);
    #1;
    if (en && m_rdv) begin
      e = rd_q.pop_front();
      m_rdata = e.v; m_rdata8 = e.v8;
    end
    check("rd_valid", rd_valid, m_rdv);
    check("rdata", rdata, m_rdata);
    check("rd_valid8", rd_valid8, m_rdv);
    check("rdata8", rdata8, m_rdata8);
    check("tx_valid", tx_valid, sb.size() > 0);
    check("tx_head", {tx_chan, tx_data}, (sb.size() > 0) ? sb[0] : 10'h0);
    check("halt", halt, m_halt);
    check("exit_code", exit_code, m_exit);
  endtask

  task automatic step(input logic w, input logic r, input logic [2:0] off, input logic [31:0] d,
                      input logic rdy, input logic e = 1'b1, input logic ret = 1'b0,
                      input logic miss = 1'b0);
    set_in(w, r, off, d, rdy, e, ret, miss);
    cycle();
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 1, 0, 0);
    rstb = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rstb = 1'b1;
    model_reset();
  endtask

  function automatic vec_t mk(logic w, logic r, logic [2:0] off, logic [7:0] d, logic rdy,
                              logic e, logic miss, logic txv, logic rdv, logic [31:0] rdat);
    vec_t v;
    v.wr = w; v.rd = r; v.off = off; v.d = d; v.rdy = rdy; v.en = e; v.miss = miss;
    v.exp_txv = txv; v.exp_rdv = rdv; v.exp_rdata = rdat;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[13];
    //             wr rd off  d     rdy en miss txv rdv rdata
    vecs[0]  = mk(1, 0, 3'd0, 8'h41, 1, 1, 0,   1,  0,  0);
    vecs[1]  = mk(1, 0, 3'd1, 8'h42, 1, 1, 0,   1,  0,  0);
    vecs[2]  = mk(0, 0, 3'd0, 8'h00, 1, 1, 0,   0,  0,  0);
    vecs[3]  = mk(0, 1, 3'd6, 8'h00, 1, 1, 0,   0,  1,  0);
    vecs[4]  = mk(0, 1, 3'd4, 8'h00, 1, 0, 0,   0,  1,  0);
    vecs[5]  = mk(1, 0, 3'd2, 8'h99, 0, 1, 0,   0,  0,  0);
    vecs[6]  = mk(1, 0, 3'd0, 8'h11, 0, 1, 1,   0,  0,  0);
    vecs[7]  = mk(0, 1, 3'd4, 8'h00, 0, 1, 0,   0,  1,  6);
    vecs[8]  = mk(0, 1, 3'd5, 8'h00, 0, 1, 0,   0,  1,  0);
    vecs[9]  = mk(1, 0, 3'd1, 8'h5A, 0, 0, 0,   0,  1,  0);
    vecs[10] = mk(1, 0, 3'd1, 8'h5A, 0, 1, 0,   1,  0,  0);
    vecs[11] = mk(0, 1, 3'd6, 8'h00, 0, 1, 0,   1,  1,  1);
    vecs[12] = mk(0, 0, 3'd0, 8'h00, 1, 1, 0,   0,  0,  1);

    set_in(0, 0, 0, 0, 0, 1, 0, 0);
    #2;
    do_reset();

    // Basic stream, ignored offsets, window miss, enable gating, status.
    for (int i = 0; i < 13; i++) begin
      step(vecs[i].wr, vecs[i].rd, vecs[i].off, 32'(vecs[i].d), vecs[i].rdy, vecs[i].en,
           1'b0, vecs[i].miss);
      check($sformatf("vec%0d txv", i), tx_valid, vecs[i].exp_txv);
      check($sformatf("vec%0d rdv", i), rd_valid, vecs[i].exp_rdv);
      check($sformatf("vec%0d rdata", i), rdata, vecs[i].exp_rdata);
    end

    // Overflow: 17 pushes into a 16-deep FIFO with the sink stalled.
    do_reset();
    for (int i = 0; i <= 16; i++) step(1, 0, {2'b0, 1'(i)}, 32'(i), 0);
    step(0, 1, 3'd6, 0, 0);
    check("ovf status", rdata, 32'h80000010);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 1);
    check("ovf drained", tx_valid, 0);
    step(0, 1, 3'd6, 0, 0);
    check("ovf sticky", rdata, 32'h80000000);
    step(1, 0, 3'd6, 0, 0);
    step(0, 1, 3'd6, 0, 0);
    check("ovf cleared", rdata, 32'h00000000);

    // Push into a full FIFO while the head pops in the same cycle.
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 0, 3'd0, 32'hA0 + 32'(i), 0);
    step(1, 0, 3'd0, 32'h55, 1);
    step(0, 1, 3'd6, 0, 0);
    check("full+pop status", rdata, 32'h00000010);
    for (int i = 0; i < 15; i++) step(0, 0, 0, 0, 1);
    check("full+pop last", {tx_chan, tx_data}, 10'h055);
    step(0, 0, 0, 0, 1);
    check("full+pop empty", tx_valid, 0);

    // Counters: 100 enabled cycles, 37 retires, disabled gaps with retire high.
    do_reset();
    for (int i = 0; i < 100; i++) begin
      if (i % 10 == 5) step(0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1, i < 37);
    end
    step(0, 1, 3'd4, 0, 0);
    check("cycle count", rdata, 100);
    step(0, 1, 3'd5, 0, 0);
    check("instr count", rdata, 37);

    // Halt: exit code latched, later pushes/terminates ignored, FIFO drains, counters frozen.
    do_reset();
    step(1, 0, 3'd0, 32'h61, 0);
    check("pre-halt", halt, 0);
    step(1, 0, 3'd7, 32'h2A, 0, 1, 1);
    check("halt set", halt, 1);
    check("exit code", exit_code, 32'h2A);
    step(1, 0, 3'd0, 32'h77, 0);
    step(1, 0, 3'd7, 32'h33, 0);
    check("exit sticky", exit_code, 32'h2A);
    for (int i = 0; i < 50; i++) step(0, 0, 0, 0, 1, 1, 1);
    check("halt drained", tx_valid, 0);
    step(0, 1, 3'd4, 0, 0);
    check("frozen cycles", rdata, 2);
    step(0, 1, 3'd5, 0, 0);
    check("frozen instr", rdata, 1);

    // 8-bit counters wrap: 300 retires read as 44.
    do_reset();
    for (int i = 0; i < 300; i++) step(0, 0, 0, 0, 0, 1, 1);
    step(0, 1, 3'd5, 0, 0);
    check("instr 32b", rdata, 300);
    check("instr wrap8", rdata8, 44);
    step(0, 1, 3'd4, 0, 0);
    check("cycle 32b", rdata, 301);
    check("cycle wrap8", rdata8, 45);

    // Asynchronous reset in the middle of a drain discards the FIFO.
    for (int i = 0; i < 3; i++) step(1, 0, 3'd1, 32'hC0 + 32'(i), 0);
    step(0, 1, 3'd4, 0, 1);
    #2;
    rstb = 1'b0;
    #1;
    check_all_zero("midreset");
    model_reset();
    set_in(0, 0, 0, 0, 1, 1, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rstb = 1'b1;
    step(0, 0, 0, 0, 1);
    check("post-reset empty", tx_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
